// File: rtl/grf_mp_scoreboard.sv
// grf_mp_scoreboard: multi-port register file with two write ports, same-cycle write bypass,
// a per-register busy scoreboard and a sequential post-reset clear walk.
module grf_mp_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       wa0,
  input  logic [DATA_W-1:0]       wd0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       wa1,
  input  logic [DATA_W-1:0]       wd1,
  input  logic                    mark_en,
  input  logic [ADDR_W-1:0]       mark_addr,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*DATA_W-1:0]   rd,
  output logic [NRD-1:0]          rd_busy,
  output logic                    init_done
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic run, wv0, wv1;
  assign run       = state_q == RUN;
  assign init_done = run;
  assign wv0 = run && we0 && !((ZERO_REG != 0) && wa0 == '0);
  assign wv1 = run && we1 && !((ZERO_REG != 0) && wa1 == '0);
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      state_d   = (clr_idx_q == '1) ? RUN : CLEAR;
    end
  end
  // A mark is the newer producer, so it beats a same-cycle retiring write.
  always_comb begin
    busy_d = busy_q;
    for (int e = 0; e < DEPTH; e++)
      if (run && !((ZERO_REG != 0) && e == 0))
        busy_d[e] = (mark_en && mark_addr == ADDR_W'(e)) ? 1'b1 :
                    ((wv0 && wa0 == ADDR_W'(e)) || (wv1 && wa1 == ADDR_W'(e))) ? 1'b0 : busy_q[e];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end
  // No reset on the array itself; the walk clears it so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem_q[clr_idx_q] <= '0;
    else begin
      if (wv0) mem_q[wa0] <= wd0;
      if (wv1) mem_q[wa1] <= wd1;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic z, h0, h1;
    assign a  = ra[k*ADDR_W +: ADDR_W];
    assign z  = (ZERO_REG != 0) && a == '0;
    assign h1 = wv1 && wa1 == a;
    assign h0 = wv0 && wa0 == a;
    assign rd[k*DATA_W +: DATA_W] = (!run || z) ? '0 : h1 ? wd1 : h0 ? wd0 : mem_q[a];
    assign rd_busy[k] = run && !z && busy_q[a] && !(h0 || h1);
  end
endmodule

// File: tb/tb_grf_mp_scoreboard.sv
// tb_grf_mp_scoreboard: table-driven vectors checked through an expected-result queue,
// plus hand-written reset / clear-walk sequences.
module tb_grf_mp_scoreboard;
  logic clk = 0, reset = 0;
  logic we0 = 0, we1 = 0, mark_en = 0;
  logic [4:0] wa0 = 0, wa1 = 0, mark_addr = 0, ra0 = 0, ra1 = 0;
  logic [31:0] wd0 = 0, wd1 = 0;
  logic [9:0] ra;
  logic [63:0] rd;
  logic [1:0] rd_busy;
  logic init_done;
  int tests = 0, fails = 0;

  typedef struct {
    logic we0; logic [4:0] wa0; logic [31:0] wd0;
    logic we1; logic [4:0] wa1; logic [31:0] wd1;
    logic mk;  logic [4:0] ma;
    logic [4:0] ra0; logic [4:0] ra1;
    logic [31:0] rd0; logic [31:0] rd1; logic [1:0] bsy;
  } vec_t;
  typedef struct { logic [31:0] rd0; logic [31:0] rd1; logic [1:0] bsy; } exp_t;
  exp_t q[$];
  vec_t tbl[16];

  assign ra = {ra1, ra0};
  always #5 clk = ~clk;

  grf_mp_scoreboard dut (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .mark_en(mark_en), .mark_addr(mark_addr),
    .ra(ra), .rd(rd), .rd_busy(rd_busy), .init_done(init_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
    we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
    mark_en = v.mk; mark_addr = v.ma; ra0 = v.ra0; ra1 = v.ra1;
    q.push_back('{v.rd0, v.rd1, v.bsy});
    #1;
    e = q.pop_front();
    chk({tag, "_rd0"}, rd[31:0], e.rd0);
    chk({tag, "_rd1"}, rd[63:32], e.rd1);
    chk({tag, "_busy"}, {30'd0, rd_busy}, {30'd0, e.bsy});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; we0 = 0; we1 = 0; mark_en = 0;
    @(negedge clk);
    reset = 0;
  endtask

  // Called right after reset drops; counts low-phase samples with init_done = 0
  // while trying to write and mark reg 3, which must be ignored.
  task automatic walk(input string tag);
    int n = 0;
    bit done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (init_done) begin
        done = 1;
        we0 = 0; mark_en = 0;
      end else begin
        n++;
        we0 = 1; wa0 = 3; wd0 = 32'hDEADBEEF; mark_en = 1; mark_addr = 3; ra0 = 3; ra1 = 3;
        #1;
        if (c == 0 || c == 20) begin
          chk($sformatf("%s_clr_rd_c%0d", tag, c), rd[31:0], 32'd0);
          chk($sformatf("%s_clr_busy_c%0d", tag, c), {30'd0, rd_busy}, 32'd0);
        end
        @(negedge clk);
      end
    end
    chk({tag, "_walk_len"}, n, 32);
    chk({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
  endtask

  initial begin
    tbl[0]  = '{0,0,0,            0,0,0,            0,0, 3,0,  32'h0,        32'h0,        2'b00};
    tbl[1]  = '{1,5,32'h11111111, 0,0,0,            0,0, 5,5,  32'h11111111, 32'h11111111, 2'b00};
    tbl[2]  = '{0,0,0,            0,0,0,            0,0, 5,3,  32'h11111111, 32'h0,        2'b00};
    tbl[3]  = '{1,7,32'hAAAA0000, 1,7,32'h0000BBBB, 0,0, 7,7,  32'h0000BBBB, 32'h0000BBBB, 2'b00};
    tbl[4]  = '{0,0,0,            0,0,0,            0,0, 7,5,  32'h0000BBBB, 32'h11111111, 2'b00};
    tbl[5]  = '{1,0,32'h12345678, 1,0,32'h12345678, 1,0, 0,0,  32'h0,        32'h0,        2'b00};
    tbl[6]  = '{0,0,0,            0,0,0,            0,0, 0,0,  32'h0,        32'h0,        2'b00};
    tbl[7]  = '{0,0,0,            0,0,0,            1,9, 9,0,  32'h0,        32'h0,        2'b00};
    tbl[8]  = '{0,0,0,            0,0,0,            0,0, 9,9,  32'h0,        32'h0,        2'b11};
    tbl[9]  = '{1,9,32'h99,       0,0,0,            0,0, 9,9,  32'h99,       32'h99,       2'b00};
    tbl[10] = '{0,0,0,            0,0,0,            0,0, 9,0,  32'h99,       32'h0,        2'b00};
    tbl[11] = '{0,0,0,            1,9,32'h55,       1,9, 9,0,  32'h55,       32'h0,        2'b00};
    tbl[12] = '{0,0,0,            0,0,0,            0,0, 9,9,  32'h55,       32'h55,       2'b11};
    tbl[13] = '{1,10,32'hA,       0,0,0,            0,0, 9,10, 32'h55,       32'hA,        2'b01};
    tbl[14] = '{1,13,32'hD,       1,12,32'hC,       0,0, 12,13,32'hC,        32'hD,        2'b00};
    tbl[15] = '{0,0,0,            0,0,0,            0,0, 13,9, 32'hD,        32'h55,       2'b10};

    do_reset();
    walk("first");
    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("v%0d", i));

    do_reset();
    repeat (10) @(negedge clk);
    chk("midwalk_not_done", {31'd0, init_done}, 32'd0);
    do_reset();
    walk("second");
    for (int e = 0; e < 32; e += 2)
      apply('{0,0,0, 0,0,0, 0,0, 5'(e), 5'(e+1), 32'h0, 32'h0, 2'b00}, $sformatf("sweep%0d", e));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
